fec_ctrl: RTL and testbench
===========================

FEC_CTRL -- requirements
Module: fec_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 9, bit-counter width; it must cover the largest count (384).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 SHALL provide port rate_id  input  4  burst profile; sampled with start.
REQ-006 SHALL provide port in_valid  input  1  source bit valid.
REQ-007 SHALL provide port in_bits  input  1  source data bit.
REQ-008 SHALL provide port in_ready  output  1  controller accepts source bit this cycle.
REQ-009 SHALL provide port rs_valid  output  1  data bit to RS encoder valid.
REQ-010 SHALL provide port rs_bit  output  1  data bit to RS encoder.
REQ-011 SHALL provide port rs_sob  output  1  first bit of RS block, coincident with the first rs_valid.
REQ-012 SHALL provide port rs_par_req  output  1  RS encoder shifts out one parity bit per asserted cycle.
REQ-013 SHALL provide port cc_flush  output  1  CC encoder shifts in a zero tail bit per asserted cycle.
REQ-014 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-015 SHALL provide port done  output  1  one-cycle burst-complete pulse.
REQ-016 SHALL provide port err  output  1  one-cycle pulse for a rejected start.

Function
REQ-017 SHALL map rate_id 0,1,2,3 to data bits D = 96,192,288,384 and parity bits P = 0,32,64,128.
REQ-018 SHALL treat rate_id 4..15 as invalid.
REQ-019 SHALL implement states IDLE, DATA, PARITY, TAIL, DONE.
REQ-020 IDLE: start with valid rate_id -> latch D and P, clear counter, enter DATA next cycle.
REQ-021 IDLE: start with invalid rate_id -> err high for exactly the next cycle, remain IDLE, latch nothing.
REQ-022 DATA: in_ready = 1; rs_valid = in_valid; rs_bit = in_bits (combinational pass-through, zero latency); counter increments on each in_valid beat.
REQ-023 DATA: in_valid low stalls the controller with no count change and no timeout.
REQ-024 DATA: rs_sob SHALL assert only on the beat where counter = 0 and in_valid = 1.
REQ-025 DATA: on the beat making counter = D, clear counter; go to PARITY if P > 0, else go to TAIL.
REQ-026 PARITY: rs_par_req high for exactly P consecutive cycles; in_ready = 0; then go to TAIL.
REQ-027 TAIL: cc_flush high for exactly 6 consecutive cycles (CC constraint length 7 zero-tail); then go to DONE.
REQ-028 DONE: done high for one cycle, then return to IDLE; a start in this cycle SHALL be ignored.
REQ-029 start in any non-IDLE state SHALL be ignored: no err, no relatch.
REQ-030 in_ready, rs_valid, rs_par_req and cc_flush SHALL be mutually exclusive and low outside their states.
REQ-031 Latched D/P SHALL stay constant for the whole burst regardless of rate_id changes.
REQ-032 Burst length from leaving IDLE to done SHALL equal (D + P + 6 + 1) cycles, plus stall cycles.

Reset
REQ-033 reset low SHALL, asynchronously, force IDLE, clear counter and latched D/P, and drive all outputs to 0.
REQ-034 reset asserted mid-burst SHALL abandon the burst without done or err; the next burst SHALL start cleanly after release.
REQ-035 The first rising edge after reset release SHALL be able to sample start.

Verification
REQ-036 rate_id=0 start, in_valid continuous -> 96 rs_valid cycles (first with rs_sob), 0 rs_par_req, 6 cc_flush, done at cycle 103 after start, busy low one cycle later.
REQ-037 rate_id=3 with in_valid low every 3rd cycle -> exactly 384 accepted bits, bits forwarded in order, 128 rs_par_req, 6 cc_flush, then one done.
REQ-038 rate_id=9 start -> err pulse one cycle, busy stays 0, no other output toggles.
REQ-039 start pulses during DATA, PARITY and DONE of a rate_id=1 burst -> ignored; exactly one done; counts 192/32/6.
REQ-040 reset low at bit 50 of a rate_id=2 burst -> all outputs 0 immediately; after release, a rate_id=1 burst completes with correct counts.
REQ-041 rate_id changed from 1 to 0 mid-burst -> burst completes with 192/32/6 counts.

Source files
------------

// File: rtl/fec_ctrl.sv
// rtl/fec_ctrl.sv - burst controller sequencing RS data, RS parity and CC zero-tail phases
//
// Purpose: accepts a burst request with a rate profile, forwards D source bits to the
// RS encoder, requests P RS parity bits, flushes the CC encoder with 6 zero tail bits
// and pulses done. Invalid profiles are rejected with a one-cycle err pulse.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   burst request, only honoured in IDLE
//   rate_id     in   [3:0] burst profile, sampled with start (0..3 valid)
//   in_valid    in   source bit valid
//   in_bits     in   source data bit
//   in_ready    out  source bit accepted this cycle (DATA phase)
//   rs_valid    out  data bit to RS encoder valid
//   rs_bit      out  data bit to RS encoder
//   rs_sob      out  first bit of the RS block
//   rs_par_req  out  RS parity shift request
//   cc_flush    out  CC zero-tail shift request
//   busy        out  controller not idle
//   done        out  one-cycle burst-complete pulse
//   err         out  one-cycle rejected-start pulse
module fec_ctrl #(
    parameter int DW = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rate_id,
    input  logic       in_valid,
    input  logic       in_bits,
    output logic       in_ready,
    output logic       rs_valid,
    output logic       rs_bit,
    output logic       rs_sob,
    output logic       rs_par_req,
    output logic       cc_flush,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_TAIL   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Zero-tail length for a constraint-length-7 convolutional code.
    localparam logic [DW-1:0] TAIL_LEN = DW'(6);
    localparam logic [DW-1:0] ONE      = DW'(1);

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] p_q, p_d;
    logic          err_q, err_d;

    logic          rate_ok;
    logic [DW-1:0] rate_d_bits;
    logic [DW-1:0] rate_p_bits;

    // Profile table: data and parity bit counts per rate_id.
    always_comb begin
        rate_ok     = (rate_id[3:2] == 2'b00);
        rate_d_bits = '0;
        rate_p_bits = '0;
        case (rate_id[1:0])
            2'd0: begin rate_d_bits = DW'(96);  rate_p_bits = DW'(0);   end
            2'd1: begin rate_d_bits = DW'(192); rate_p_bits = DW'(32);  end
            2'd2: begin rate_d_bits = DW'(288); rate_p_bits = DW'(64);  end
            default: begin rate_d_bits = DW'(384); rate_p_bits = DW'(128); end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    // One counter is reused by every phase; it is cleared on each phase exit so the
    // next phase always counts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        p_d     = p_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rate_ok) begin
                        d_d     = rate_d_bits;
                        p_d     = rate_p_bits;
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    if (cnt_q == d_q - ONE) begin
                        cnt_d   = '0;
                        state_d = (p_q != '0) ? S_PARITY : S_TAIL;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == p_q - ONE) begin
                    cnt_d   = '0;
                    state_d = S_TAIL;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_TAIL: begin
                if (cnt_q == TAIL_LEN - ONE) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data path is a zero-latency pass-through while in DATA.
    always_comb begin
        in_ready   = 1'b0;
        rs_valid   = 1'b0;
        rs_bit     = 1'b0;
        rs_sob     = 1'b0;
        rs_par_req = 1'b0;
        cc_flush   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        err        = err_q;
        case (state_q)
            S_DATA: begin
                in_ready = 1'b1;
                rs_valid = in_valid;
                rs_bit   = in_valid & in_bits;
                rs_sob   = in_valid && (cnt_q == '0);
            end
            S_PARITY: rs_par_req = 1'b1;
            S_TAIL:   cc_flush   = 1'b1;
            S_DONE:   done       = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fec_ctrl.sv
// tb/tb_fec_ctrl.sv - randomized self-checking bench for fec_ctrl
module tb_fec_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rate_id = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_bits = 1'b0;
    logic       in_ready, rs_valid, rs_bit, rs_sob, rs_par_req, cc_flush, busy, done, err;

    int checks = 0;
    int errors = 0;

    fec_ctrl #(.DW(9)) dut (
        .clk(clk), .reset(reset), .start(start), .rate_id(rate_id),
        .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
        .rs_valid(rs_valid), .rs_bit(rs_bit), .rs_sob(rs_sob),
        .rs_par_req(rs_par_req), .cc_flush(cc_flush), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Observations of the most recent burst.
    int o_data, o_sob, o_sob_bad, o_par, o_flush, o_done, o_err, o_done_cyc;
    int o_stalls, o_rdy, o_excl_bad, o_busy_bad, o_order_bad, o_busy_after;
    bit o_timeout, o_rst_zero;
    int m_d, m_p;

    function automatic int d_of(input int r);
        return 96 * (r + 1);
    endfunction

    function automatic int p_of(input int r);
        int t[4] = '{0, 32, 64, 128};
        return t[r];
    endfunction

    // Issues a burst from a point away from the clock edge and observes it cycle by
    // cycle. mode: 0 continuous valid, 1 valid low every 3rd cycle, 2 random stalls.
    task automatic run_burst(input int rate, input int mode, input bit poke,
                             input bit change, input int rst_at);
        bit exp_q[$];
        bit got_q[$];
        int acc;
        bit drv_v, drv_b, post;
        m_d = d_of(rate); m_p = p_of(rate);
        o_data = 0; o_sob = 0; o_sob_bad = 0; o_par = 0; o_flush = 0; o_done = 0;
        o_err = 0; o_done_cyc = -1; o_stalls = 0; o_rdy = 0; o_excl_bad = 0;
        o_busy_bad = 0; o_order_bad = 0; o_busy_after = -1; o_timeout = 1; o_rst_zero = 0;
        acc = 0; post = 0;
        start = 1'b1; rate_id = 4'(rate); in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (rst_at >= 0 && acc == rst_at) begin
                reset = 1'b0;
                #1;
                o_rst_zero = ({in_ready, rs_valid, rs_bit, rs_sob, rs_par_req,
                               cc_flush, busy, done, err} == 9'd0);
                in_valid = 1'b0;
                @(negedge clk);
                if (done || err || busy) o_rst_zero = 0;
                @(negedge clk);
                reset = 1'b1;
                o_timeout = 0;
                return;
            end
            drv_v = 1'b0;
            if (acc < m_d) begin
                case (mode)
                    0: drv_v = 1'b1;
                    1: drv_v = (cyc % 3) != 0;
                    default: drv_v = ($urandom_range(0, 3) != 0);
                endcase
                if (!drv_v) o_stalls++;
            end
            drv_b = 1'($urandom);
            in_valid = drv_v; in_bits = drv_b;
            if (drv_v) begin exp_q.push_back(drv_b); acc++; end
            start = poke && (cyc == 10 || cyc == 200 || cyc == 231);
            if (start) rate_id = 4'd2;
            if (change && cyc == 50) rate_id = 4'd0;
            @(negedge clk);
            if (rs_valid) begin
                if (rs_sob !== (got_q.size() == 0)) o_sob_bad++;
                got_q.push_back(rs_bit);
                o_data++;
            end else if (rs_sob) o_sob_bad++;
            if (rs_sob) o_sob++;
            if (in_ready) o_rdy++;
            if (rs_par_req) o_par++;
            if (cc_flush) o_flush++;
            if (err) o_err++;
            if ((int'(in_ready) + int'(rs_par_req) + int'(cc_flush) + int'(done)) > 1 ||
                (rs_valid && !in_ready)) o_excl_bad++;
            if (post) begin
                o_busy_after = int'(busy);
                if (done) o_done++;
                o_timeout = 0;
                break;
            end
            if (!busy) o_busy_bad++;
            if (done) begin
                o_done++;
                o_done_cyc = cyc;
                post = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        start = 1'b0; in_valid = 1'b0;
        if (got_q.size() != exp_q.size()) o_order_bad++;
        else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) o_order_bad++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks++;
        if ({in_ready, rs_valid, rs_bit, rs_sob, rs_par_req, cc_flush, busy, done, err} !== 9'd0) begin
            errors++; $display("FAIL reset_outs got %b exp 0",
                {in_ready, rs_valid, rs_bit, rs_sob, rs_par_req, cc_flush, busy, done, err});
        end
        start = 1'b1; rate_id = 4'd1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, rs_valid, rs_bit, rs_sob, rs_par_req, cc_flush, busy, done, err} !== 9'd0) begin
            errors++; $display("FAIL reset_hold got %b exp 0",
                {in_ready, rs_valid, rs_bit, rs_sob, rs_par_req, cc_flush, busy, done, err});
        end
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_rate0;
        run_burst(0, 0, 0, 0, -1);
        checks++; if (o_data !== 96) begin errors++; $display("FAIL r0_data got %0d exp 96", o_data); end
        checks++; if (o_sob !== 1 || o_sob_bad !== 0) begin errors++; $display("FAIL r0_sob got %0d bad %0d exp 1/0", o_sob, o_sob_bad); end
        checks++; if (o_par !== 0) begin errors++; $display("FAIL r0_par got %0d exp 0", o_par); end
        checks++; if (o_flush !== 6) begin errors++; $display("FAIL r0_flush got %0d exp 6", o_flush); end
        checks++; if (o_done !== 1 || o_done_cyc !== 103) begin errors++; $display("FAIL r0_done got %0d at %0d exp 1 at 103", o_done, o_done_cyc); end
        checks++; if (o_busy_after !== 0 || o_busy_bad !== 0) begin errors++; $display("FAIL r0_busy after %0d bad %0d exp 0/0", o_busy_after, o_busy_bad); end
        checks++; if (o_order_bad !== 0 || o_excl_bad !== 0) begin errors++; $display("FAIL r0_order got %0d excl %0d exp 0/0", o_order_bad, o_excl_bad); end
        checks++; if (o_timeout !== 0 || o_err !== 0) begin errors++; $display("FAIL r0_term timeout %0d err %0d exp 0/0", o_timeout, o_err); end
    endtask

    task automatic test_rate3_stall;
        run_burst(3, 1, 0, 0, -1);
        checks++; if (o_data !== 384 || o_order_bad !== 0) begin errors++; $display("FAIL r3_data got %0d order %0d exp 384/0", o_data, o_order_bad); end
        checks++; if (o_rdy !== 384 + o_stalls) begin errors++; $display("FAIL r3_ready got %0d exp %0d", o_rdy, 384 + o_stalls); end
        checks++; if (o_par !== 128 || o_flush !== 6) begin errors++; $display("FAIL r3_par_flush got %0d/%0d exp 128/6", o_par, o_flush); end
        checks++; if (o_done !== 1 || o_done_cyc !== 384 + 128 + 7 + o_stalls) begin
            errors++; $display("FAIL r3_done got %0d at %0d exp 1 at %0d", o_done, o_done_cyc, 384 + 128 + 7 + o_stalls); end
        checks++; if (o_sob_bad !== 0 || o_excl_bad !== 0) begin errors++; $display("FAIL r3_sob_excl got %0d/%0d exp 0/0", o_sob_bad, o_excl_bad); end
    endtask

    task automatic test_invalid;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = (k == 0) ? 9 : $urandom_range(4, 15);
            start = 1'b1; rate_id = 4'(r);
            @(posedge clk); #1;
            start = 1'b0; rate_id = 4'd0;
            @(negedge clk);
            checks++;
            if ({err, busy, in_ready, rs_valid, rs_sob, rs_par_req, cc_flush, done} !== 8'b1000_0000) begin
                errors++; $display("FAIL inv_pulse rate %0d got %b exp 10000000", r,
                    {err, busy, in_ready, rs_valid, rs_sob, rs_par_req, cc_flush, done});
            end
            @(negedge clk);
            checks++;
            if ({err, busy, done} !== 3'b000) begin
                errors++; $display("FAIL inv_after rate %0d got %b exp 000", r, {err, busy, done});
            end
        end
    endtask

    task automatic test_ignore_start;
        run_burst(1, 0, 1, 0, -1);
        checks++; if (o_data !== 192 || o_par !== 32 || o_flush !== 6) begin
            errors++; $display("FAIL ign_counts got %0d/%0d/%0d exp 192/32/6", o_data, o_par, o_flush); end
        checks++; if (o_done !== 1 || o_err !== 0 || o_busy_after !== 0) begin
            errors++; $display("FAIL ign_done got %0d err %0d busy_after %0d exp 1/0/0", o_done, o_err, o_busy_after); end
        checks++; if (o_done_cyc !== 231) begin errors++; $display("FAIL ign_latency got %0d exp 231", o_done_cyc); end
    endtask

    task automatic test_reset_mid;
        run_burst(2, 0, 0, 0, 50);
        checks++; if (o_rst_zero !== 1 || o_done !== 0 || o_err !== 0) begin
            errors++; $display("FAIL rst_mid zero %0d done %0d err %0d exp 1/0/0", o_rst_zero, o_done, o_err); end
        run_burst(1, 2, 0, 0, -1);
        checks++; if (o_data !== 192 || o_par !== 32 || o_flush !== 6 || o_order_bad !== 0) begin
            errors++; $display("FAIL rst_next got %0d/%0d/%0d order %0d exp 192/32/6/0", o_data, o_par, o_flush, o_order_bad); end
        checks++; if (o_done !== 1 || o_done_cyc !== 192 + 32 + 7 + o_stalls) begin
            errors++; $display("FAIL rst_next_done got %0d at %0d exp 1 at %0d", o_done, o_done_cyc, 192 + 32 + 7 + o_stalls); end
    endtask

    task automatic test_rate_change;
        run_burst(1, 0, 0, 1, -1);
        checks++; if (o_data !== 192 || o_par !== 32 || o_flush !== 6 || o_done !== 1) begin
            errors++; $display("FAIL chg_counts got %0d/%0d/%0d done %0d exp 192/32/6/1", o_data, o_par, o_flush, o_done); end
    endtask

    task automatic test_random;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 3);
            run_burst(r, 2, 0, 0, -1);
            checks++; if (o_data !== m_d || o_order_bad !== 0 || o_sob !== 1) begin
                errors++; $display("FAIL rnd_data rate %0d got %0d order %0d sob %0d exp %0d/0/1", r, o_data, o_order_bad, o_sob, m_d); end
            checks++; if (o_par !== m_p || o_flush !== 6) begin
                errors++; $display("FAIL rnd_par rate %0d got %0d/%0d exp %0d/6", r, o_par, o_flush, m_p); end
            checks++; if (o_done !== 1 || o_done_cyc !== m_d + m_p + 7 + o_stalls || o_excl_bad !== 0) begin
                errors++; $display("FAIL rnd_done rate %0d got %0d at %0d excl %0d exp 1 at %0d", r, o_done, o_done_cyc, o_excl_bad, m_d + m_p + 7 + o_stalls); end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_rate0();
        test_rate3_stall();
        test_invalid();
        test_ignore_start();
        test_reset_mid();
        test_rate_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
